// File: rtl/maple_rx_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maple_rx_frame_checker: length/XOR check on received Maple frames | rev 1.0 |
// +----------------------------------------------------------------------------+
module maple_rx_frame_checker #(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int C_COUNT_WIDTH      = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [1:0]                    m_axis_tuser,
  input  logic                          m_axis_tready,
  input  logic                          clear_counters,
  output logic                          frame_active,
  output logic [C_COUNT_WIDTH-1:0]      good_count,
  output logic [C_COUNT_WIDTH-1:0]      crc_err_count,
  output logic [C_COUNT_WIDTH-1:0]      short_count,
  output logic [C_COUNT_WIDTH-1:0]      long_count
);

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    BODY    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [1:0] C_ST_OK    = 2'b00;
  localparam logic [1:0] C_ST_CRC   = 2'b01;
  localparam logic [1:0] C_ST_SHORT = 2'b10;
  localparam logic [1:0] C_ST_LONG  = 2'b11;

  state_t                          state_q, state_d;
  logic [10:0]                     idx_q, idx_d;
  logic [10:0]                     len_q, len_d;
  logic [7:0]                      xor_q, xor_d;
  logic [C_AXIS_TDATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                            m_valid_q, m_valid_d;
  logic                            m_last_q, m_last_d;
  logic [1:0]                      m_user_q, m_user_d;
  logic [C_COUNT_WIDTH-1:0]        cnt_q [4];
  logic [C_COUNT_WIDTH-1:0]        cnt_d [4];

  logic s_ready;
  logic accept;
  logic beat_done;

  // DISCARD drops bytes without touching the output register, so it never stalls.
  assign s_ready       = (state_q == DISCARD) || !m_valid_q || m_axis_tready;
  assign s_axis_tready = areset || s_ready;
  assign accept        = s_axis_tvalid && s_ready;
  assign beat_done     = m_valid_q && m_axis_tready && m_last_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    xor_d    = xor_q;
    m_data_d = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d = m_last_q;
    m_user_d = m_user_q;

    if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      if (state_q != DISCARD) begin
        m_data_d  = s_axis_tdata;
        m_valid_d = 1'b1;
        m_last_d  = 1'b0;
        m_user_d  = C_ST_OK;
      end
      case (state_q)
        HEADER: begin
          len_d = 11'd5 + {1'b0, s_axis_tdata[7:0], 2'b00};
          idx_d = 11'd1;
          xor_d = s_axis_tdata[7:0];
          if (s_axis_tlast) begin
            m_last_d = 1'b1;
            m_user_d = C_ST_SHORT;
            idx_d    = 11'd0;
            xor_d    = 8'd0;
          end else begin
            state_d = BODY;
          end
        end
        BODY: begin
          if (idx_q != len_q - 11'd1) begin
            if (s_axis_tlast) begin
              m_last_d = 1'b1;
              m_user_d = C_ST_SHORT;
              state_d  = HEADER;
              idx_d    = 11'd0;
              xor_d    = 8'd0;
            end else begin
              xor_d = xor_q ^ s_axis_tdata[7:0];
              idx_d = idx_q + 11'd1;
            end
          end else begin
            // Checksum position reached: length error outranks checksum error.
            m_last_d = 1'b1;
            idx_d    = 11'd0;
            xor_d    = 8'd0;
            if (s_axis_tlast) begin
              m_user_d = (s_axis_tdata[7:0] == xor_q) ? C_ST_OK : C_ST_CRC;
              state_d  = HEADER;
            end else begin
              m_user_d = C_ST_LONG;
              state_d  = DISCARD;
            end
          end
        end
        DISCARD: begin
          if (s_axis_tlast) begin
            state_d = HEADER;
          end
        end
        default: begin
          state_d = HEADER;
        end
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clear_counters) begin
        cnt_d[k] = '0;
      end else if (beat_done && (m_user_q == 2'(k)) && (cnt_q[k] != '1)) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= HEADER;
      idx_q     <= '0;
      len_q     <= '0;
      xor_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_user_q  <= 2'b00;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      xor_q     <= xor_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_user_q  <= m_user_d;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign frame_active  = (state_q != HEADER);
  assign good_count    = cnt_q[0];
  assign crc_err_count = cnt_q[1];
  assign short_count   = cnt_q[2];
  assign long_count    = cnt_q[3];

endmodule
`default_nettype wire

// File: tb/tb_maple_rx_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_maple_rx_frame_checker: directed frames with expected-beat queue | rev 1.0 |
// +----------------------------------------------------------------------------+
module tb_maple_rx_frame_checker;

  localparam int CW = 4;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [7:0]    s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [7:0]    m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic [1:0]    m_tuser;
  logic          m_tready = 1'b1;
  logic          clear_counters = 1'b0;
  logic          frame_active;
  logic [CW-1:0] good_count, crc_err_count, short_count, long_count;

  maple_rx_frame_checker #(.C_AXIS_TDATA_WIDTH(8), .C_COUNT_WIDTH(CW)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .clear_counters(clear_counters), .frame_active(frame_active),
    .good_count(good_count), .crc_err_count(crc_err_count),
    .short_count(short_count), .long_count(long_count)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [1:0] u;
  } beat_t;

  beat_t         sb[$];
  logic [7:0]    frm[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [CW-1:0] exp_cnt [4] = '{default: '0};
  bit            rand_rdy = 1'b0;
  bit            chk_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: pops expected beats, tracks expected counters, checks stall hold.
  initial begin
    beat_t e;
    beat_t prev;
    bit    stall_prev;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        stall_prev = 1'b0;
        for (int k = 0; k < 4; k++) exp_cnt[k] = '0;
      end else begin
        if (stall_prev) begin
          check("hold_stable", {m_tvalid, m_tdata, m_tlast, m_tuser}, {1'b1, prev});
        end
        if (m_tvalid && m_tready) begin
          check("beat_expected", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("beat", {m_tdata, m_tlast, m_tuser}, e);
            if (e.l && exp_cnt[e.u] != '1) exp_cnt[e.u] = exp_cnt[e.u] + 1'b1;
          end
        end
        if (chk_rdy) check("s_tready", s_tready, !(m_tvalid && !m_tready));
        if (clear_counters) begin
          for (int k = 0; k < 4; k++) exp_cnt[k] = '0;
        end
        stall_prev = m_tvalid && !m_tready;
        prev = {m_tdata, m_tlast, m_tuser};
      end
    end
  end

  task automatic drive(input bit final_last);
    int  t;
    bit  ok;
    for (int i = 0; i < frm.size(); i++) begin
      s_tdata  = frm[i];
      s_tvalid = 1'b1;
      s_tlast  = final_last && (i == frm.size() - 1);
      t = 0;
      do begin
        @(negedge aclk);
        ok = s_tready;
        @(posedge aclk);
        #1;
        t++;
      end while (!ok && t < 2000);
      if (!ok) check("s_tready_timeout", 32'(ok), 1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Reference: frame length 5+4N, checksum = XOR of all preceding bytes.
  task automatic send_frame();
    int         n;
    int         len;
    logic [7:0] x;
    n   = frm.size();
    len = 5 + 4 * int'(frm[0]);
    x   = 8'h00;
    if (n < len) begin
      for (int i = 0; i < n; i++) sb.push_back({frm[i], i == n - 1, (i == n - 1) ? 2'b10 : 2'b00});
    end else begin
      for (int i = 0; i < len - 1; i++) begin
        sb.push_back({frm[i], 1'b0, 2'b00});
        x = x ^ frm[i];
      end
      if (n == len) sb.push_back({frm[len-1], 1'b1, (frm[len-1] == x) ? 2'b00 : 2'b01});
      else          sb.push_back({frm[len-1], 1'b1, 2'b11});
    end
    drive(1'b1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 5000) begin
      @(posedge aclk);
      t++;
    end
    check("drain", sb.size(), 0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_good"},  good_count,    exp_cnt[0]);
    check({tag, "_crc"},   crc_err_count, exp_cnt[1]);
    check({tag, "_short"}, short_count,   exp_cnt[2]);
    check({tag, "_long"},  long_count,    exp_cnt[3]);
  endtask

  initial begin
    logic [7:0] x;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_s_tready", s_tready, 1);
    check("rst_m_tvalid", m_tvalid, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    check("rst_outs", {m_tvalid, m_tlast, m_tuser, m_tdata}, 0);
    check("rst_frame_active", frame_active, 0);
    check("rst_cnt", {good_count, crc_err_count, short_count, long_count}, 0);

    frm = {8'h00, 8'h00, 8'h20, 8'h01, 8'h21};
    send_frame();
    drain();
    check("good1", good_count, 1);
    check_counters("f_good");

    frm = {8'h00, 8'h00, 8'h20, 8'h01, 8'h22};
    send_frame();
    frm = {8'h01, 8'h00, 8'h20, 8'h01, 8'hAA, 8'hBB};
    send_frame();
    frm = {8'h00, 8'h00, 8'h20, 8'h01, 8'h21, 8'h33, 8'h44};
    send_frame();
    frm = {8'h00, 8'h00, 8'h20, 8'h01, 8'h21};
    send_frame();
    frm = {8'h07};
    send_frame();
    drain();
    check("crc1", crc_err_count, 1);
    check_counters("f_mix");

    rand_rdy = 1'b1;
    chk_rdy  = 1'b1;
    frm = {8'hFF, 8'h01, 8'h02, 8'h03};
    x = 8'hFF ^ 8'h01 ^ 8'h02 ^ 8'h03;
    for (int i = 0; i < 1020; i++) begin
      frm.push_back(8'($urandom));
      x = x ^ frm[frm.size() - 1];
    end
    frm.push_back(x);
    send_frame();
    drain();
    rand_rdy = 1'b0;
    chk_rdy  = 1'b0;
    check_counters("f_long255");

    frm = {8'h00, 8'h00, 8'h20};
    for (int i = 0; i < 3; i++) sb.push_back({frm[i], 1'b0, 2'b00});
    drive(1'b0);
    drain();
    check("abort_active", frame_active, 1);
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst2_s_tready", s_tready, 1);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    check("rst2_frame_active", frame_active, 0);
    check("rst2_m_tvalid", m_tvalid, 0);
    frm = {8'h00, 8'h00, 8'h20, 8'h01, 8'h21};
    send_frame();
    drain();
    check_counters("f_after_rst");

    for (int i = 0; i < 15; i++) begin
      frm = {8'h00, 8'h10, 8'h20, 8'h01, 8'h31};
      send_frame();
    end
    drain();
    check("sat_good", good_count, {CW{1'b1}});
    frm = {8'h00, 8'h10, 8'h20, 8'h01, 8'h31};
    send_frame();
    drain();
    check("sat_hold", good_count, {CW{1'b1}});

    frm = {8'h00, 8'h00, 8'h20, 8'h01, 8'h21};
    send_frame();
    clear_counters = 1'b1;
    @(posedge aclk);
    #1;
    clear_counters = 1'b0;
    drain();
    check("clear_good", good_count, 0);
    check_counters("f_clear");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/maple_rx_frame_checker.md
MAPLE_RX_FRAME_CHECKER -- requirements
Module: maple_rx_frame_checker

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 8, stream byte width; only 8 is supported.
REQ-002 SHALL have parameter C_COUNT_WIDTH, default 16, width of each frame statistics counter.
REQ-003 SHALL use a single clock and a synchronous, active-high reset.
REQ-004 aclk  in  1  clock; all logic on rising edge.
REQ-005 areset  in  1  synchronous active-high reset.
REQ-006 s_axis_tdata  in  8  received Maple byte, from the rx FIFO master side.
REQ-007 s_axis_tvalid  in  1  input byte valid.
REQ-008 s_axis_tlast  in  1  last byte of the received frame.
REQ-009 s_axis_tready  out  1  byte accepted.
REQ-010 m_axis_tdata  out  8  forwarded byte.
REQ-011 m_axis_tvalid  out  1  output byte valid.
REQ-012 m_axis_tlast  out  1  last byte of the checked frame.
REQ-013 m_axis_tuser  out  2  status on the tlast beat: 00 ok, 01 checksum error, 10 short frame, 11 long frame; 00 on all other beats.
REQ-014 m_axis_tready  in  1  downstream ready.
REQ-015 clear_counters  in  1  one-cycle pulse that zeroes all statistics counters.
REQ-016 frame_active  out  1  high while the checker is inside a frame, i.e. state is not HEADER.
REQ-017 good_count, crc_err_count, short_count, long_count  out  C_COUNT_WIDTH each  frame statistics.

Function
REQ-018 Frame layout: byte0 = N (32-bit payload word count, 0..255), byte1 = sender, byte2 = recipient, byte3 = command, then 4N payload bytes, then one checksum byte; expected length L = 5 + 4N bytes (max 1025).
REQ-019 Checksum byte SHALL equal the XOR of bytes 0..L-2.
REQ-020 Transfer occurs on s_axis_tvalid && s_axis_tready.
REQ-021 s_axis_tready SHALL equal !m_axis_tvalid || m_axis_tready.
REQ-022 Output register: an accepted byte appears on m_axis_* the next cycle; latency is exactly 1 cycle; throughput is 1 byte/cycle under no backpressure.
REQ-023 m_axis_* SHALL hold stable while m_axis_tvalid && !m_axis_tready.
REQ-024 Byte index counter, 11 bits, SHALL reset to 0 at every frame start; running XOR SHALL reset to 0 at every frame start.
REQ-025 States SHALL be HEADER, BODY and DISCARD.
REQ-026 HEADER: the accepted byte is byte0; capture N, compute L, forward the byte, go to BODY.
REQ-027 HEADER with s_axis_tlast on byte0: forward it with tlast=1, tuser=10, stay in HEADER.
REQ-028 BODY, index < L-1 and input tlast=1: forward with tlast=1, tuser=10, go to HEADER.
REQ-029 BODY, index < L-1 and input tlast=0: forward with tlast=0, update XOR.
REQ-030 BODY, index = L-1 and input tlast=1: forward with tlast=1; tuser=00 if byte equals XOR, else 01; go to HEADER.
REQ-031 BODY, index = L-1 and input tlast=0: forward with tlast forced to 1, tuser=11 (length error has priority over checksum error), go to DISCARD.
REQ-032 DISCARD: s_axis_tready=1 and bytes are dropped, with no output; on an accepted tlast, go to HEADER.
REQ-033 Each output tlast beat SHALL increment exactly one counter by tuser value (00 good, 01 crc, 10 short, 11 long), at the output handshake.
REQ-034 Counters SHALL saturate at all-ones.
REQ-035 clear_counters SHALL win over a simultaneous increment, leaving the counter at 0.

Reset
REQ-036 On areset: state HEADER, index 0, XOR 0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=00, m_axis_tdata=0, all counters 0, frame_active=0.
REQ-037 Reset mid-frame SHALL discard the partial frame without emitting a tlast; the next accepted byte is treated as byte0.
REQ-038 While areset is high, s_axis_tready SHALL be 1, with no output produced.

Verification
REQ-039 Send 00 00 20 01 21, tlast on byte 5 -> 5 beats out in order, last has tlast=1, tuser=00; good_count=1.
REQ-040 Send 00 00 20 01 22, tlast on byte 5 -> last beat tuser=01; crc_err_count=1.
REQ-041 Send 01 00 20 01 AA BB, tlast on byte 6 -> byte BB out with tlast=1, tuser=10; short_count=1.
REQ-042 Send 00 00 20 01 21 33 44, tlast on byte 7 -> 5 beats out, byte 21 with tlast=1, tuser=11; 33 and 44 dropped; the following valid frame reports 00.
REQ-043 Send N=255 frame (1025 bytes) with m_axis_tready random at 50% -> all bytes out in order, none lost or duplicated, tuser=00; s_axis_tready low exactly when m_axis_tvalid && !m_axis_tready.
REQ-044 Assert areset after byte 3 of a frame, then send a good N=0 frame -> no tlast from the aborted frame, new frame tuser=00; then preload good_count at all-ones via 2^C_COUNT_WIDTH good frames -> holds all-ones; clear_counters with a coincident good frame -> 0.
